// File: rtl/eq_mac_scheduler_if.sv
// Frame bus between the FIR bank and the EQ MAC scheduler: start pulse, band
// samples, gain/volume pots, and the equalized output with its status flags.
interface eq_mac_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 12
);
  logic                     start;
  logic signed [DATA_W-1:0] LP_lft, LP_rght, B1_lft, B1_rght, B2_lft;
  logic signed [DATA_W-1:0] B2_rght, B3_lft, B3_rght, HP_lft, HP_rght;
  logic        [COEF_W-1:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, POT_VOL;
  logic signed [DATA_W-1:0] aud_out_lft, aud_out_rght;
  logic                     out_vld, busy, ovr;

  modport master (
    output start, LP_lft, LP_rght, B1_lft, B1_rght, B2_lft, B2_rght,
           B3_lft, B3_rght, HP_lft, HP_rght,
           POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, POT_VOL,
    input  aud_out_lft, aud_out_rght, out_vld, busy, ovr
  );

  modport slave (
    input  start, LP_lft, LP_rght, B1_lft, B1_rght, B2_lft, B2_rght,
           B3_lft, B3_rght, HP_lft, HP_rght,
           POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, POT_VOL,
    output aud_out_lft, aud_out_rght, out_vld, busy, ovr
  );
endinterface

// File: rtl/eq_mac_scheduler.sv
// Five-band stereo equalizer MAC: one shared signed 16x13 multiplier runs ten
// band-gain steps and two volume steps per frame, then emits both channels.
module eq_mac_scheduler #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 12,
  parameter int STAGES = 5
) (
  input logic               clk,
  input logic               rst_n,
  eq_mac_scheduler_if.slave bus
);
  localparam int NSTEP  = 2 * STAGES;
  localparam int ACC_W  = DATA_W + 3;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam logic [4:0] LAST_BAND = 5'(NSTEP - 1);
  localparam logic [4:0] VOL_LFT   = 5'(NSTEP);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, BAND, VOL} state_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [PROD_W-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return x[DATA_W-1:0];
  endfunction

  state_t                   state, state_nx;
  logic [4:0]               cnt;
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic signed [DATA_W-1:0] samp_in   [NSTEP];
  logic [COEF_W-1:0]        pot_in    [STAGES];
  logic signed [DATA_W-1:0] snap_samp [NSTEP];
  logic [COEF_W-1:0]        snap_pot  [STAGES];
  logic [COEF_W-1:0]        snap_vol;
  logic [3:0]               samp_idx;
  logic [2:0]               pot_idx;
  logic signed [DATA_W-1:0] mul_a;
  logic signed [COEF_W:0]   mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] band_scaled, vol_res, lft_hold, aud_l, aud_r;
  logic                     accept, band_en, vol_l, vol_r, ovr_set;
  logic                     out_vld_r, busy_r, ovr_r;

  assign samp_in[0] = bus.LP_lft;  assign samp_in[1] = bus.LP_rght;
  assign samp_in[2] = bus.B1_lft;  assign samp_in[3] = bus.B1_rght;
  assign samp_in[4] = bus.B2_lft;  assign samp_in[5] = bus.B2_rght;
  assign samp_in[6] = bus.B3_lft;  assign samp_in[7] = bus.B3_rght;
  assign samp_in[8] = bus.HP_lft;  assign samp_in[9] = bus.HP_rght;
  assign pot_in[0]  = bus.POT_LP;  assign pot_in[1]  = bus.POT_B1;
  assign pot_in[2]  = bus.POT_B2;  assign pot_in[3]  = bus.POT_B3;
  assign pot_in[4]  = bus.POT_HP;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = BAND;
      BAND:    if (cnt == LAST_BAND) state_nx = VOL;
      VOL:     if (cnt != VOL_LFT) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    band_en = 1'b0;
    vol_l   = 1'b0;
    vol_r   = 1'b0;
    ovr_set = bus.start && (state != IDLE);
    case (state)
      IDLE: accept  = bus.start;
      BAND: band_en = 1'b1;
      VOL: begin
        vol_l = (cnt == VOL_LFT);
        vol_r = (cnt != VOL_LFT);
      end
      default: ;
    endcase
  end

  // Frame snapshot: inputs are free to change once the frame has started.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NSTEP; i++)  snap_samp[i] <= samp_in[i];
      for (int i = 0; i < STAGES; i++) snap_pot[i]  <= pot_in[i];
      snap_vol <= bus.POT_VOL;
    end
    if (vol_l) lft_hold <= vol_res;
  end

  // Shared multiplier: band sample x gain during BAND, saturated acc x volume during VOL.
  assign samp_idx = (state == BAND) ? cnt[3:0] : 4'd0;
  assign pot_idx  = samp_idx[3:1];

  always_comb begin
    mul_a = snap_samp[samp_idx];
    mul_b = {1'b0, snap_pot[pot_idx]};
    if (state == VOL) begin
      mul_a = sat16(PROD_W'(vol_l ? acc_l : acc_r));
      mul_b = {1'b0, snap_vol};
    end
  end

  assign prod        = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign band_scaled = sat16(prod >>> (COEF_W - 1));
  assign vol_res     = prod[DATA_W+COEF_W-1:COEF_W];

  // Accumulate / output register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      aud_l     <= '0;
      aud_r     <= '0;
      out_vld_r <= 1'b0;
      busy_r    <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      out_vld_r <= 1'b0;
      if (ovr_set) ovr_r <= 1'b1;
      if (accept) begin
        cnt    <= '0;
        acc_l  <= '0;
        acc_r  <= '0;
        busy_r <= 1'b1;
      end else if (band_en) begin
        cnt <= cnt + 5'd1;
        if (cnt[0]) acc_r <= acc_r + ACC_W'(band_scaled);
        else        acc_l <= acc_l + ACC_W'(band_scaled);
      end else if (vol_l) begin
        cnt <= cnt + 5'd1;
      end else if (vol_r) begin
        aud_l     <= lft_hold;
        aud_r     <= vol_res;
        out_vld_r <= 1'b1;
        busy_r    <= 1'b0;
      end
    end
  end

  assign bus.aud_out_lft  = aud_l;
  assign bus.aud_out_rght = aud_r;
  assign bus.out_vld      = out_vld_r;
  assign bus.busy         = busy_r;
  assign bus.ovr          = ovr_r;
endmodule

// File: tb/tb_eq_mac_scheduler.sv
// Randomized bench for eq_mac_scheduler against an arithmetic frame model.
module tb_eq_mac_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eq_mac_scheduler_if bus ();
  eq_mac_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  int s [10];
  int p [5];
  int v;
  int exp_l, exp_r;
  int vld_seen = 0;
  int vld_exp  = 0;
  int lat;

  always @(negedge clk) if (bus.out_vld === 1'b1) vld_seen++;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp16(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model(output int el, output int er);
    longint acc [2];
    acc[0] = 0;
    acc[1] = 0;
    for (int k = 0; k < 10; k++)
      acc[k % 2] += clamp16(fdiv(longint'(s[k]) * longint'(p[k / 2]), 2048));
    el = int'(fdiv(clamp16(acc[0]) * longint'(v), 4096));
    er = int'(fdiv(clamp16(acc[1]) * longint'(v), 4096));
  endtask

  task automatic apply();
    bus.LP_lft = 16'(s[0]); bus.LP_rght = 16'(s[1]);
    bus.B1_lft = 16'(s[2]); bus.B1_rght = 16'(s[3]);
    bus.B2_lft = 16'(s[4]); bus.B2_rght = 16'(s[5]);
    bus.B3_lft = 16'(s[6]); bus.B3_rght = 16'(s[7]);
    bus.HP_lft = 16'(s[8]); bus.HP_rght = 16'(s[9]);
    bus.POT_LP = 12'(p[0]); bus.POT_B1 = 12'(p[1]); bus.POT_B2 = 12'(p[2]);
    bus.POT_B3 = 12'(p[3]); bus.POT_HP = 12'(p[4]); bus.POT_VOL = 12'(v);
  endtask

  task automatic rand_stim();
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 4))
        0:       s[k] = 32767;
        1:       s[k] = -32768;
        2:       s[k] = int'($signed(16'($urandom_range(0, 511)))) - 256;
        default: s[k] = int'($signed(16'($urandom)));
      endcase
    end
    for (int b = 0; b < 5; b++) begin
      case ($urandom_range(0, 3))
        0:       p[b] = 4095;
        1:       p[b] = 0;
        2:       p[b] = 2048;
        default: p[b] = int'($urandom_range(0, 4095));
      endcase
    end
    v = ($urandom_range(0, 3) == 0) ? 4095 : int'($urandom_range(0, 4095));
  endtask

  task automatic wait_vld(output int n_edges);
    n_edges = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus.out_vld === 1'b1) begin
        n_edges = n;
        break;
      end
    end
  endtask

  task automatic frame(input string tag);
    int l;
    model(exp_l, exp_r);
    apply();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_e0"}, int'(bus.busy), 1);
    chk({tag, "_vld_low_e0"}, int'(bus.out_vld), 0);
    wait_vld(l);
    chk({tag, "_latency"}, l, 12);
    chk({tag, "_lft"}, int'(bus.aud_out_lft), exp_l);
    chk({tag, "_rght"}, int'(bus.aud_out_rght), exp_r);
    chk({tag, "_busy_at_vld"}, int'(bus.busy), 0);
    vld_exp++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b1;
    v = 0;
    for (int k = 0; k < 10; k++) s[k] = 0;
    for (int b = 0; b < 5; b++) p[b] = 0;
    apply();
    tick();
    tick();
    chk("rst_lft", int'(bus.aud_out_lft), 0);
    chk("rst_rght", int'(bus.aud_out_rght), 0);
    chk("rst_vld", int'(bus.out_vld), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ovr", int'(bus.ovr), 0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    tick();
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_vld", int'(bus.out_vld), 0);

    for (int k = 0; k < 10; k++) s[k] = (k % 2 == 0) ? 256 : -256;
    for (int b = 0; b < 5; b++) p[b] = 2048;
    v = 4095;
    frame("unity");
    chk("unity_lft_const", int'(bus.aud_out_lft), int'($signed(16'h04FF)));
    chk("unity_rght_const", int'(bus.aud_out_rght), int'($signed(16'hFB00)));
    rand_stim();
    apply();
    repeat (3) tick();
    chk("hold_lft", int'(bus.aud_out_lft), exp_l);
    chk("hold_rght", int'(bus.aud_out_rght), exp_r);

    for (int k = 0; k < 10; k++) s[k] = 32767;
    for (int b = 0; b < 5; b++) p[b] = 4095;
    v = 2048;
    frame("sat");
    chk("sat_lft_const", int'(bus.aud_out_lft), int'($signed(16'h3FFF)));
    chk("sat_rght_const", int'(bus.aud_out_rght), int'($signed(16'h3FFF)));

    for (int i = 0; i < 20; i++) begin
      int gap;
      rand_stim();
      frame("rand");
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        rand_stim();
        apply();
        repeat (gap) tick();
        chk("rand_hold_lft", int'(bus.aud_out_lft), exp_l);
        chk("rand_hold_rght", int'(bus.aud_out_rght), exp_r);
      end
    end
    chk("rand_ovr", int'(bus.ovr), 0);

    rand_stim();
    frame("b2b_a");
    rand_stim();
    frame("b2b_b");
    chk("b2b_ovr", int'(bus.ovr), 0);

    rand_stim();
    model(exp_l, exp_r);
    apply();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) s[k] = 0;
    apply();
    repeat (4) tick();
    chk("ovr_before", int'(bus.ovr), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ovr_set", int'(bus.ovr), 1);
    wait_vld(lat);
    chk("ovr_latency", lat, 7);
    chk("snap_lft", int'(bus.aud_out_lft), exp_l);
    chk("snap_rght", int'(bus.aud_out_rght), exp_r);
    vld_exp++;
    repeat (15) tick();
    chk("ovr_sticky", int'(bus.ovr), 1);

    rand_stim();
    apply();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_lft", int'(bus.aud_out_lft), 0);
    chk("abort_rght", int'(bus.aud_out_rght), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_vld", int'(bus.out_vld), 0);
    chk("abort_ovr_clr", int'(bus.ovr), 0);
    rst_n = 1'b1;
    tick();
    rand_stim();
    frame("abort_rerun");
    chk("abort_rerun_ovr", int'(bus.ovr), 0);

    repeat (3) tick();
    chk("vld_pulse_count", vld_seen, vld_exp);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/eq_mac_scheduler.md
EQ_MAC_SCHEDULER -- requirements
Module: eq_mac_scheduler

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; a new set of five FIR outputs is ready.
- LP_lft, LP_rght, B1_lft, B1_rght, B2_lft, B2_rght, B3_lft, B3_rght, HP_lft, HP_rght  in  16 each  signed FIR band samples.
- POT_LP, POT_B1, POT_B2, POT_B3, POT_HP  in  12 each  unsigned band gain pots.
- POT_VOL  in  12  unsigned volume pot.
- aud_out_lft, aud_out_rght  out  16 each  signed equalized, volume-scaled output.
- out_vld  out  1  one-cycle pulse; aud_out_* updated this cycle.
- busy  out  1  high while a frame is in progress.
- ovr  out  1  sticky: a start arrived while not IDLE.

Function
REQ-003 The block SHALL contain exactly one signed 16x13 multiplier, time-shared across all 12 products of a frame.
REQ-004 The FSM SHALL have states IDLE, BAND, VOL; reset state IDLE.
REQ-005 IDLE->BAND on an edge with start=1; at that edge (E0), all ten band samples and all six pots SHALL be snapshotted; later input changes SHALL NOT affect the frame.
REQ-006 E0 SHALL clear a 5-bit step counter and both 19-bit signed accumulators (acc_l, acc_r).
REQ-007 BAND SHALL last 10 cycles (edges E1..E10); step k (0..9) selects band k/2 in order LP, B1, B2, B3, HP; even k is left, odd k is right.
REQ-008 Band product: scaled = sat16((sample * {1'b0,POT}) >>> 11), arithmetic shift, floor rounding; 0x800 is unity gain.
REQ-009 Each BAND edge SHALL add scaled (sign-extended to 19 bits) into acc_l for even k and acc_r for odd k.
REQ-010 BAND->VOL at E10; VOL SHALL last 2 cycles: E11 left, E12 right.
REQ-011 Volume product: out = bits [27:12] of the 29-bit signed product sat16(acc) * {1'b0,POT_VOL}; no further saturation.
REQ-012 At E11 the block SHALL hold the left result internally; at E12 it SHALL load aud_out_lft and aud_out_rght together, assert out_vld for exactly one cycle, and return to IDLE.
REQ-013 aud_out_* SHALL hold their value between frames.
REQ-014 busy SHALL be 1 from E0 up to E12 and 0 from E12 onward, including during the out_vld cycle.
REQ-015 start=1 at any edge while the state is not IDLE (E1..E12 inclusive) SHALL be ignored, SHALL leave the frame unaffected, and SHALL set ovr.
REQ-016 ovr SHALL clear only on reset.
REQ-017 start in the first cycle after the out_vld cycle SHALL be accepted; the frame period is therefore 13 cycles minimum.
REQ-018 sat16 SHALL clamp to the range [-32768, 32767].

Reset
REQ-019 On an edge with rst_n=0, the block SHALL set state=IDLE, counter=0, acc_l=acc_r=0, aud_out_lft=aud_out_rght=0, out_vld=0, busy=0, ovr=0.
REQ-020 Reset mid-frame SHALL abort the frame with no out_vld; the next start after release SHALL run a full frame normally.
REQ-021 A start coinciding with rst_n=0 SHALL be ignored.

Verification
REQ-022 Reset: rst_n=0 for 2 cycles with start=1 -> all outputs 0, busy=0, no out_vld.
REQ-023 Unity, mixed sign: all band POTs=0x800, every *_lft=0x0100, every *_rght=0xFF00, POT_VOL=0xFFF, one start -> out_vld exactly 12 edges after E0, aud_out_lft=0x04FF, aud_out_rght=0xFB00.
REQ-024 Saturation: all samples=0x7FFF, band POTs=0xFFF, POT_VOL=0x800 -> aud_out_lft=aud_out_rght=0x3FFF.
REQ-025 Overrun and snapshot: start at E0, then start again at E5, and all samples changed to 0 at E1 -> one out_vld, results equal the E0 snapshot, ovr=1 after E5.
REQ-026 Abort: rst_n=0 at E6 -> no out_vld, outputs 0; start 2 cycles later -> correct result 12 edges after its E0.
REQ-027 Back-to-back: start in the cycle right after out_vld -> accepted, ovr stays 0, second out_vld 12 edges later.
